ps2_mouse_init_ctrl: RTL

PS2_MOUSE_INIT_CTRL -- requirements
Module: ps2_mouse_init_ctrl

---
 rtl/ps2_pkg.sv | 30 +++
 rtl/ps2_mouse_packet.sv | 71 +++++++
 rtl/ps2_mouse_init_ctrl.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared types and protocol constants for the PS/2 mouse init controller and packet assembler.
package ps2_pkg;

   typedef enum logic [2:0] {
      ST_SEND_RST,
      ST_WAIT_ACK_RST,
      ST_WAIT_BAT,
      ST_WAIT_ID,
      ST_SEND_EN,
      ST_WAIT_ACK_EN,
      ST_STREAM,
      ST_ERROR
   } state_t;

   localparam logic [7:0] CMD_RESET    = 8'hFF;
   localparam logic [7:0] CMD_ENABLE   = 8'hF4;
   localparam logic [7:0] RSP_ACK      = 8'hFA;
   localparam logic [7:0] RSP_RESEND   = 8'hFE;
   localparam logic [7:0] RSP_BAT_OK   = 8'hAA;
   localparam logic [7:0] RSP_BAT_FAIL = 8'hFC;
   localparam logic [7:0] RSP_MOUSE_ID = 8'h00;

   localparam int TIMER_W = 26;

   // Movement deltas carry their sign in packet byte 0, separate from the magnitude byte.
   function automatic logic [8:0] make_delta(input logic sign, input logic [7:0] value);
      return {sign, value};
   endfunction

endpackage

// File: rtl/ps2_mouse_packet.sv
// Assembles 3-byte PS/2 mouse movement packets into button, delta and overflow fields.
module ps2_mouse_packet
   import ps2_pkg::*;
(
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       en_i,
   input  logic       clear_i,
   input  logic       rx_done_i,
   input  logic [7:0] rx_data_i,
   output logic       pkt_valid_o,
   output logic [2:0] btn_o,
   output logic [8:0] dx_o,
   output logic [8:0] dy_o,
   output logic [1:0] ovf_o
);

   logic [1:0] idx_q;
   // Byte 0 minus its always-one sync bit: {ovf_y, ovf_x, sign_y, sign_x, btn[2:0]}
   logic [6:0] hdr_q;
   logic [7:0] dx_byte_q;
   logic       pkt_valid_q;
   logic [2:0] btn_q;
   logic [8:0] dx_q;
   logic [8:0] dy_q;
   logic [1:0] ovf_q;

   always_ff @(posedge clk_i) begin
      pkt_valid_q <= 1'b0;
      if (reset_i) begin
         idx_q     <= 2'd0;
         hdr_q     <= '0;
         dx_byte_q <= '0;
         btn_q     <= '0;
         dx_q      <= '0;
         dy_q      <= '0;
         ovf_q     <= '0;
      end else if (clear_i) begin
         idx_q <= 2'd0;
      end else if (en_i && rx_done_i) begin
         case (idx_q)
            2'd0: begin
               if (rx_data_i[3]) begin
                  hdr_q <= {rx_data_i[7:4], rx_data_i[2:0]};
                  idx_q <= 2'd1;
               end
            end
            2'd1: begin
               dx_byte_q <= rx_data_i;
               idx_q     <= 2'd2;
            end
            2'd2: begin
               pkt_valid_q <= 1'b1;
               btn_q       <= hdr_q[2:0];
               dx_q        <= make_delta(hdr_q[3], dx_byte_q);
               dy_q        <= make_delta(hdr_q[4], rx_data_i);
               ovf_q       <= hdr_q[6:5];
               idx_q       <= 2'd0;
            end
            default: idx_q <= 2'd0;
         endcase
      end
   end

   assign pkt_valid_o = pkt_valid_q;
   assign btn_o       = btn_q;
   assign dx_o        = dx_q;
   assign dy_o        = dy_q;
   assign ovf_o       = ovf_q;

endmodule

// File: rtl/ps2_mouse_init_ctrl.sv
// PS/2 mouse bring-up FSM: reset, BAT/ID check, enable streaming, then hand bytes to the packet assembler.
module ps2_mouse_init_ctrl
   import ps2_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 50_000_000,
   parameter int MAX_RETRIES    = 3
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       restart_i,
   input  logic       tx_idle_i,
   input  logic       tx_done_i,
   output logic       tx_en_o,
   output logic [7:0] tx_data_o,
   input  logic       rx_done_i,
   input  logic [7:0] rx_data_i,
   output logic       init_done_o,
   output logic       error_o,
   output logic       pkt_valid_o,
   output logic [2:0] btn_o,
   output logic [8:0] dx_o,
   output logic [8:0] dy_o,
   output logic [1:0] ovf_o
);

   localparam int                   RETRY_W    = $clog2(MAX_RETRIES + 1) + 1;
   localparam logic [TIMER_W-1:0]   TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
   localparam logic [RETRY_W-1:0]   RETRY_MAX  = RETRY_W'(MAX_RETRIES);

   state_t               state_q;
   logic                 sent_q;
   logic                 tx_en_q;
   logic [7:0]           tx_data_q;
   logic [TIMER_W-1:0]   timer_q;
   logic [RETRY_W-1:0]   retry_q;

   logic timer_hit;
   logic stream_gap;
   logic pkt_en;
   logic pkt_clear;

   assign timer_hit  = (timer_q == TIMER_LAST);
   // A stalled packet in STREAM only drops the partial bytes; the FSM stays put.
   assign stream_gap = (state_q == ST_STREAM) && !rx_done_i && timer_hit;
   assign pkt_en     = (state_q == ST_STREAM);
   assign pkt_clear  = restart_i || !pkt_en || stream_gap;

   always_ff @(posedge clk_i) begin
      tx_en_q <= 1'b0;
      if (reset_i || restart_i) begin
         state_q   <= ST_SEND_RST;
         sent_q    <= 1'b0;
         tx_data_q <= CMD_RESET;
         timer_q   <= '0;
         retry_q   <= '0;
      end else begin
         unique case (state_q)
            ST_SEND_RST, ST_SEND_EN: begin
               if (!sent_q) begin
                  if (tx_idle_i) begin
                     tx_en_q <= 1'b1;
                     sent_q  <= 1'b1;
                  end
               end else if (tx_done_i) begin
                  sent_q  <= 1'b0;
                  timer_q <= '0;
                  state_q <= (state_q == ST_SEND_RST) ? ST_WAIT_ACK_RST : ST_WAIT_ACK_EN;
               end
            end

            ST_WAIT_ACK_RST, ST_WAIT_BAT, ST_WAIT_ID, ST_WAIT_ACK_EN: begin
               if (rx_done_i) begin
                  timer_q <= '0;
                  case (state_q)
                     ST_WAIT_ACK_RST: begin
                        if (rx_data_i == RSP_ACK) begin
                           state_q <= ST_WAIT_BAT;
                        end else if (rx_data_i == RSP_RESEND) begin
                           state_q   <= ST_SEND_RST;
                           tx_data_q <= CMD_RESET;
                        end
                     end
                     ST_WAIT_BAT: begin
                        if (rx_data_i == RSP_BAT_OK) begin
                           state_q <= ST_WAIT_ID;
                        end else if (rx_data_i == RSP_BAT_FAIL) begin
                           state_q <= ST_ERROR;
                        end
                     end
                     ST_WAIT_ID: begin
                        if (rx_data_i == RSP_MOUSE_ID) begin
                           state_q   <= ST_SEND_EN;
                           tx_data_q <= CMD_ENABLE;
                        end else begin
                           state_q <= ST_ERROR;
                        end
                     end
                     default: begin
                        if (rx_data_i == RSP_ACK) begin
                           state_q <= ST_STREAM;
                           retry_q <= '0;
                        end else if (rx_data_i == RSP_RESEND) begin
                           state_q   <= ST_SEND_EN;
                           tx_data_q <= CMD_ENABLE;
                        end
                     end
                  endcase
               end else if (timer_hit) begin
                  timer_q <= '0;
                  if (retry_q == RETRY_MAX) begin
                     state_q <= ST_ERROR;
                  end else begin
                     retry_q   <= retry_q + RETRY_W'(1);
                     state_q   <= ST_SEND_RST;
                     tx_data_q <= CMD_RESET;
                  end
               end else begin
                  timer_q <= timer_q + TIMER_W'(1);
               end
            end

            ST_STREAM: begin
               if (rx_done_i || timer_hit) begin
                  timer_q <= '0;
               end else begin
                  timer_q <= timer_q + TIMER_W'(1);
               end
            end

            default: begin
            end
         endcase
      end
   end

   assign tx_en_o     = tx_en_q;
   assign tx_data_o   = tx_data_q;
   assign init_done_o = (state_q == ST_STREAM);
   assign error_o     = (state_q == ST_ERROR);

   ps2_mouse_packet u_packet (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .en_i        (pkt_en),
      .clear_i     (pkt_clear),
      .rx_done_i   (rx_done_i),
      .rx_data_i   (rx_data_i),
      .pkt_valid_o (pkt_valid_o),
      .btn_o       (btn_o),
      .dx_o        (dx_o),
      .dy_o        (dy_o),
      .ovf_o       (ovf_o)
   );

endmodule
